seg7_scan: RTL and testbench



---
 rtl/seg7_scan.sv | 134 +++++++++++++
 tb/tb_seg7_scan.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// seg7_scan: 4-digit multiplexed common-anode 7-segment driver.
// Ports: clk, rst_n, bcd_0..3, dp_sel, blank_lz, disp_en -> an, seg, dp, frame_tick.
module seg7_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYC    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bcd_0,
    input  logic [3:0] bcd_1,
    input  logic [3:0] bcd_2,
    input  logic [3:0] bcd_3,
    input  logic [3:0] dp_sel,
    input  logic       blank_lz,
    input  logic       disp_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          loaded_q;
    logic [3:0]    dig_q [4];
    logic [3:0]    dpsel_q;
    logic          lz_q;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          ft_q, ft_d;

    logic          cnt_wrap;
    logic          frame_end;
    logic          load;
    logic          active;
    logic          blank;
    logic [3:0]    cur;
    logic [3:0]    zero;
    logic [3:0]    lz_vec;

    function automatic logic [6:0] dec7(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h3F;
        unique case (v)
            4'd0: s = 7'h40;
            4'd1: s = 7'h79;
            4'd2: s = 7'h24;
            4'd3: s = 7'h30;
            4'd4: s = 7'h19;
            4'd5: s = 7'h12;
            4'd6: s = 7'h02;
            4'd7: s = 7'h78;
            4'd8: s = 7'h00;
            4'd9: s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_wrap  = (cnt_q == CNT_MAX);
        frame_end = cnt_wrap && (idx_q == 2'd3);
        load      = !loaded_q || frame_end;
        cnt_d     = cnt_wrap ? '0 : cnt_q + CW'(1);
        idx_d     = cnt_wrap ? idx_q + 2'd1 : idx_q;

        for (int i = 0; i < 4; i++) begin
            zero[i] = (dig_q[i] == 4'd0);
        end
        // Digit i blanks only when it and every more-significant digit are 0.
        lz_vec[3] = zero[3];
        lz_vec[2] = zero[3] & zero[2];
        lz_vec[1] = zero[3] & zero[2] & zero[1];
        lz_vec[0] = 1'b0;

        cur    = dig_q[idx_q];
        blank  = lz_q && lz_vec[idx_q];
        active = disp_en && (cnt_q >= CNT_DEAD);

        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (active) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = blank ? 7'h7F : dec7(cur);
            dp_d  = ~dpsel_q[idx_q];
        end
        ft_d = frame_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            loaded_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                dig_q[i] <= '0;
            end
            dpsel_q  <= '0;
            lz_q     <= 1'b0;
            an_q     <= 4'hF;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
            ft_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            loaded_q <= 1'b1;
            if (load) begin
                dig_q[0] <= bcd_0;
                dig_q[1] <= bcd_1;
                dig_q[2] <= bcd_2;
                dig_q[3] <= bcd_3;
                dpsel_q  <= dp_sel;
                lz_q     <= blank_lz;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            ft_q  <= ft_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: randomized and directed checks of seg7_scan.
// Reference derives expected outputs from the cycle count since reset.
module tb_seg7_scan;

    localparam int DIV  = 8;
    localparam int DEAD = 2;
    localparam int FRM  = 4 * DIV;

    logic       clk;
    logic       rst_n;
    logic [3:0] bcd [4];
    logic [3:0] dp_sel;
    logic       blank_lz;
    logic       disp_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int n_chk;
    int n_fail;
    int e;
    int sh_d [4];
    int sh_dp;
    int sh_lz;
    int SEG [16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                     'h00, 'h10, 'h3F, 'h3F, 'h3F, 'h3F, 'h3F, 'h3F};

    seg7_scan #(.REFRESH_DIV(DIV), .DEAD_CYC(DEAD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_0      (bcd[0]),
        .bcd_1      (bcd[1]),
        .bcd_2      (bcd[2]),
        .bcd_3      (bcd[3]),
        .dp_sel     (dp_sel),
        .blank_lz   (blank_lz),
        .disp_en    (disp_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)",
                         tag, obs, exp, e, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_an"}, an, 'hF);
        chk({tag, "_seg"}, seg, 'h7F);
        chk({tag, "_dp"}, dp, 1);
        chk({tag, "_ft"}, frame_tick, 0);
    endtask

    task automatic model_clear();
        e = 0;
        for (int j = 0; j < 4; j++) sh_d[j] = 0;
        sh_dp = 0;
        sh_lz = 0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            int c;
            int ix;
            int act;
            int blk;
            int ea;
            int es;
            int ed;
            int ef;
            int ld;
            c   = e % DIV;
            ix  = (e / DIV) % 4;
            act = (disp_en && c >= DEAD) ? 1 : 0;
            blk = 0;
            if (sh_lz != 0 && ix != 0) begin
                blk = 1;
                for (int j = ix; j < 4; j++)
                    if (sh_d[j] != 0) blk = 0;
            end
            ea = act ? (~(1 << ix)) & 15 : 15;
            es = (act == 0 || blk != 0) ? 'h7F : SEG[sh_d[ix]];
            ed = act ? (((sh_dp >> ix) & 1) ^ 1) : 1;
            ef = ((e % FRM) == FRM - 1) ? 1 : 0;
            ld = (e == 0 || ef != 0) ? 1 : 0;
            @(posedge clk);
            #1;
            if (ld != 0) begin
                for (int j = 0; j < 4; j++) sh_d[j] = int'(bcd[j]);
                sh_dp = int'(dp_sel);
                sh_lz = int'(blank_lz);
            end
            chk("an", an, ea);
            chk("seg", seg, es);
            chk("dp", dp, ed);
            chk("frame_tick", frame_tick, ef);
            e++;
        end
    endtask

    task automatic set_bcd(input int d3, input int d2, input int d1, input int d0);
        bcd[3] = 4'(d3);
        bcd[2] = 4'(d2);
        bcd[1] = 4'(d1);
        bcd[0] = 4'(d0);
    endtask

    function automatic int rnd_dig();
        return ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 15));
    endfunction

    initial begin
        n_chk  = 0;
        n_fail = 0;
        model_clear();
        rst_n    = 1'b0;
        set_bcd(3, 2, 1, 0);
        dp_sel   = 4'b0000;
        blank_lz = 1'b0;
        disp_en  = 1'b1;
        #22;
        chk_reset("rst");
        rst_n = 1'b1;
        run(2 * FRM);

        set_bcd(0, 0, 4, 7);
        blank_lz = 1'b1;
        run(2 * FRM);

        set_bcd(0, 0, 0, 0);
        run(2 * FRM);

        blank_lz = 1'b0;
        set_bcd(1, 1, 1, 5);
        run(FRM + 8);
        bcd[0] = 4'd9;
        run(FRM + 28);

        set_bcd(0, 12, 0, 3);
        blank_lz = 1'b1;
        run(2 * FRM);

        set_bcd(4, 3, 2, 1);
        blank_lz = 1'b0;
        dp_sel   = 4'b0100;
        run(FRM + DIV + 4);
        disp_en = 1'b0;
        run(3);
        disp_en = 1'b1;
        run(2 * FRM);

        for (int k = 0; k < 700; k++) begin
            if ($urandom_range(0, 7) == 0)
                set_bcd(rnd_dig(), rnd_dig(), rnd_dig(), rnd_dig());
            if ($urandom_range(0, 15) == 0) dp_sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) disp_en = ~disp_en;
            run(1);
        end

        disp_en = 1'b1;
        while ((e % FRM) != 2 * DIV + 5) run(1);
        chk("pre_rst_an", an, 'hB);
        rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        @(posedge clk);
        #1;
        chk_reset("hold_rst");
        set_bcd(0, 0, 6, 8);
        blank_lz = 1'b1;
        dp_sel   = 4'b0001;
        #2;
        rst_n = 1'b1;
        model_clear();
        run(2 * FRM);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
